// File: rtl/accelerator_hls_deadlock_pkg.sv
// Shared deadlock-detection definitions: report arbiter state encoding and
// process-ID width helper, also used by the per-process detect units.
package accelerator_hls_deadlock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIRM,
    ST_ORIGIN,
    ST_TRACE,
    ST_REPORT,
    ST_DONE
  } dl_state_e;

  function automatic int id_width(input int proc_num);
    return (proc_num > 1) ? $clog2(proc_num) : 1;
  endfunction

endpackage

// File: rtl/accelerator_hls_deadlock_lsb_find.sv
// Lowest-set-bit finder: returns the index of the lowest set bit of mask and
// whether any bit is set.
module accelerator_hls_deadlock_lsb_find #(
  parameter int WIDTH = 4,
  parameter int IDW   = 2
) (
  input  logic [WIDTH-1:0] mask,
  output logic [IDW-1:0]   index,
  output logic             valid
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    index = '0;
    valid = |mask;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask[i]) index = IDW'(i);
    end
  end

endmodule

// File: rtl/accelerator_hls_deadlock_report_arbiter.sv
// Deadlock report arbiter: confirms a persistent detect, launches a token from
// the lowest detecting process, collects the loop it travels and reports it.
module accelerator_hls_deadlock_report_arbiter
  import accelerator_hls_deadlock_pkg::*;
#(
  parameter  int PROC_NUM       = 4,
  parameter  int CONFIRM_CYCLES = 4,
  parameter  int TRACE_TIMEOUT  = 64,
  localparam int IDW            = id_width(PROC_NUM)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] token_vec,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic                token_clear,
  output logic                deadlock,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [IDW-1:0]      rpt_proc_id,
  output logic                rpt_last
);

  localparam logic [PROC_NUM-1:0] ONE_HOT0       = PROC_NUM'(1);
  localparam logic [7:0]          CONFIRM_TARGET = 8'(CONFIRM_CYCLES);
  localparam logic [15:0]         TIMEOUT_LAST   = 16'(TRACE_TIMEOUT - 1);

  dl_state_e           state;
  logic [7:0]          confirm_cnt;
  logic [15:0]         timeout_cnt;
  logic [PROC_NUM-1:0] seen_mask;
  logic [PROC_NUM-1:0] rpt_mask;
  logic [IDW-1:0]      origin_id;

  logic [IDW-1:0]      detect_lsb;
  logic                detect_any;
  logic [IDW-1:0]      rpt_lsb;
  logic                rpt_any;

  accelerator_hls_deadlock_lsb_find #(.WIDTH(PROC_NUM), .IDW(IDW)) u_origin_find (
    .mask  (dl_detect_vec),
    .index (detect_lsb),
    .valid (detect_any)
  );

  accelerator_hls_deadlock_lsb_find #(.WIDTH(PROC_NUM), .IDW(IDW)) u_report_find (
    .mask  (rpt_mask),
    .index (rpt_lsb),
    .valid (rpt_any)
  );

  logic [PROC_NUM-1:0] origin_bit;
  logic [PROC_NUM-1:0] seen_next;
  logic [PROC_NUM-1:0] rpt_mask_next;
  logic [7:0]          confirm_next;
  logic [15:0]         timeout_inc;
  logic                token_returned;

  always_comb begin
    origin_bit     = ONE_HOT0 << origin_id;
    seen_next      = seen_mask | (token_vec & ~origin_bit);
    rpt_mask_next  = rpt_mask & ~(ONE_HOT0 << rpt_lsb);
    confirm_next   = (state == ST_IDLE) ? 8'd1
                   : (confirm_cnt == 8'hFF) ? confirm_cnt : confirm_cnt + 8'd1;
    timeout_inc    = (timeout_cnt == 16'hFFFF) ? timeout_cnt : timeout_cnt + 16'd1;
    token_returned = token_vec[origin_id] & dl_detect_vec[origin_id];
  end

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // read in this block sees the pre-edge value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      confirm_cnt <= '0;
      timeout_cnt <= '0;
      seen_mask   <= '0;
      rpt_mask    <= '0;
      origin_id   <= '0;
      origin_vec  <= '0;
      token_clear <= 1'b0;
      deadlock    <= 1'b0;
      rpt_valid   <= 1'b0;
      rpt_proc_id <= '0;
      rpt_last    <= 1'b0;
    end else begin
      origin_vec  <= '0;
      token_clear <= 1'b0;
      unique case (state)
        ST_IDLE, ST_CONFIRM: begin
          if (!detect_any) begin
            state       <= ST_IDLE;
            confirm_cnt <= '0;
          end else if (confirm_next >= CONFIRM_TARGET) begin
            state       <= ST_ORIGIN;
            confirm_cnt <= confirm_next;
            origin_id   <= detect_lsb;
            origin_vec  <= ONE_HOT0 << detect_lsb;
            deadlock    <= 1'b1;
          end else begin
            state       <= ST_CONFIRM;
            confirm_cnt <= confirm_next;
          end
        end
        ST_ORIGIN: begin
          seen_mask   <= '0;
          timeout_cnt <= '0;
          state       <= ST_TRACE;
        end
        ST_TRACE: begin
          seen_mask   <= seen_next;
          timeout_cnt <= timeout_inc;
          // A return in the timeout cycle still counts as a completed loop.
          if (token_returned) begin
            state       <= ST_REPORT;
            token_clear <= 1'b1;
            rpt_valid   <= 1'b1;
            rpt_proc_id <= origin_id;
            rpt_last    <= (seen_next == '0);
            rpt_mask    <= seen_next;
          end else if (timeout_cnt >= TIMEOUT_LAST) begin
            state       <= ST_IDLE;
            confirm_cnt <= '0;
          end
        end
        ST_REPORT: begin
          if (rpt_ready) begin
            if (rpt_last) begin
              state     <= ST_DONE;
              rpt_valid <= 1'b0;
              rpt_last  <= 1'b0;
            end else if (rpt_any) begin
              rpt_proc_id <= rpt_lsb;
              rpt_last    <= (rpt_mask_next == '0);
              rpt_mask    <= rpt_mask_next;
            end
          end
        end
        ST_DONE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/accelerator_hls_deadlock_report_arbiter.md
ACCELERATOR_HLS_DEADLOCK_REPORT_ARBITER -- requirements
Module: accelerator_hls_deadlock_report_arbiter

Interface
REQ-001 Parameter PROC_NUM, default 4: number of monitored processes, range 2..32.
REQ-002 Parameter CONFIRM_CYCLES, default 4: consecutive cycles of detection needed before tracing, range 1..255.
REQ-003 Parameter TRACE_TIMEOUT, default 64: maximum cycles allowed for the token to return to the origin, range 2..65535.
REQ-004 clock  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 dl_detect_vec  input  PROC_NUM  per-process deadlock-detect flags from the detect units.
REQ-007 token_vec  input  PROC_NUM  per-process token-held flag, i.e. the OR of each unit's token outputs.
REQ-008 origin_vec  output  PROC_NUM  one-hot origin strobe to the detect units.
REQ-009 token_clear  output  1  clears token propagation in all detect units.
REQ-010 deadlock  output  1  sticky flag: a deadlock has been confirmed.
REQ-011 rpt_valid  output  1  report word valid.
REQ-012 rpt_ready  input  1  report consumer ready.
REQ-013 rpt_proc_id  output  IDW  process ID, where IDW = $clog2(PROC_NUM).
REQ-014 rpt_last  output  1  marks the final report word.

Function
REQ-015 FSM states: IDLE, CONFIRM, ORIGIN, TRACE, REPORT, DONE.
REQ-016 IDLE -> CONFIRM when |dl_detect_vec; the confirm counter loads 1.
REQ-017 CONFIRM: the counter increments while |dl_detect_vec; a cycle with dl_detect_vec==0 returns the FSM to IDLE and zeroes the counter.
REQ-018 CONFIRM -> ORIGIN when the counter reaches CONFIRM_CYCLES; origin_id latches the lowest-index set bit of dl_detect_vec in that cycle; deadlock sets the same cycle and stays set.
REQ-019 ORIGIN lasts exactly 1 cycle: origin_vec = 1<<origin_id; seen_mask clears to 0; the timeout counter clears; next state is TRACE.
REQ-020 origin_vec is 0 in every state except ORIGIN.
REQ-021 TRACE, each cycle: seen_mask |= token_vec & ~(1<<origin_id); the timeout counter increments.
REQ-022 TRACE -> REPORT when token_vec[origin_id] & dl_detect_vec[origin_id]; token_clear = 1 for that single cycle; the same-cycle token_vec bits are included in seen_mask.
REQ-023 TRACE -> IDLE (abort) when the timeout counter reaches TRACE_TIMEOUT-1 without return: no token_clear and no report; deadlock stays set.
REQ-024 If the return condition and the timeout occur in the same cycle, return wins.
REQ-025 REPORT, first word: rpt_proc_id = origin_id.
REQ-026 REPORT, following words: the set bits of seen_mask in ascending index order, one per handshake (rpt_valid & rpt_ready).
REQ-027 rpt_last = 1 on the final word; an empty seen_mask gives a single word carrying rpt_last.
REQ-028 While rpt_valid=1 and rpt_ready=0: rpt_proc_id and rpt_last hold stable and rpt_valid stays high.
REQ-029 REPORT -> DONE on the handshake of the rpt_last word.
REQ-030 DONE is terminal until reset: rpt_valid=0, token_clear=0, deadlock=1; dl_detect_vec is ignored.
REQ-031 Word iteration uses a seen_mask copy with the lowest set bit cleared per handshake; there is no multi-cycle search, so zero bubbles between words when rpt_ready stays high.
REQ-032 Counter widths: confirm counter 8 bits, timeout counter 16 bits; neither counter wraps (both saturate).

Reset
REQ-033 On reset low: state=IDLE; counters, seen_mask and origin_id are 0; origin_vec=0, token_clear=0, deadlock=0, rpt_valid=0, rpt_last=0, rpt_proc_id=0.
REQ-034 Reset asserted mid-TRACE or mid-REPORT takes effect immediately (asynchronously); no partial report resumes after release.

Structure
REQ-035 The state encoding enum and the IDW computation belong in the shared deadlock package used by the detect unit.
REQ-036 The lowest-set-bit finder (mask in, index plus valid out) is a sub-module, accelerator_hls_deadlock_lsb_find, instantiated twice: origin selection and report iteration.
REQ-037 No other sub-modules.

Verification
REQ-038 Confirm/abort: dl_detect_vec=4'b0100 for 3 cycles then 0, CONFIRM_CYCLES=4 -> the FSM returns to IDLE and deadlock=0.
REQ-039 Full trace: dl_detect_vec=4'b0110 held 4 cycles -> origin_id=1; origin_vec=4'b0010 for 1 cycle; then token_vec steps 4'b0100, 4'b1000, then 4'b0010 with dl_detect_vec[1]=1 -> token_clear for 1 cycle; report 1, 2, 3 with rpt_last on 3; deadlock=1.
REQ-040 Backpressure: same trace with rpt_ready=0 for 5 cycles on word 2 -> rpt_proc_id=2 held stable; no word lost or duplicated.
REQ-041 Timeout: TRACE_TIMEOUT=8, token never returns -> IDLE after 8 TRACE cycles; token_clear never asserted; rpt_valid never asserted; deadlock=1.
REQ-042 Empty path: the origin's token returns in the first TRACE cycle with token_vec only at the origin -> single word = origin_id with rpt_last=1.
REQ-043 Reset mid-REPORT: assert reset after word 1 accepted -> all outputs 0 immediately; after release, state=IDLE.
